// File: rtl/minbd_eject_buffer.sv
// Ejection buffer for a MinBD deflection router.
// A two-write, one-read show-ahead FIFO that never back-pressures the router and counts the flits it has to drop.
module minbd_eject_buffer #(
   parameter int FLIT_W  = 57,
   parameter int VLD_BIT = 32,
   parameter int DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [FLIT_W-1:0]        eject_1,
   input  logic [FLIT_W-1:0]        eject_2,
   output logic [FLIT_W-1:0]        out_flit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1_s;
   logic [CW-1:0]     count_q, count_d, free_s;
   logic              overflow_q, overflow_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              v1_s, v2_s, pop_s, wr0_en_s, wr1_en_s;
   logic [FLIT_W-1:0] wr0_data_s;
   logic [1:0]        n_wr_s, n_drop_s;
   logic [8:0]        drop_sum_s;

   // Write/drop decision and next-state computation.
   always_comb begin
      v1_s        = eject_1[VLD_BIT];
      v2_s        = eject_2[VLD_BIT];
      pop_s       = (count_q != {CW{1'b0}}) & out_ready;
      free_s      = DEPTH_C - count_q + CW'(pop_s);
      wr_ptr_p1_s = wr_ptr_q + AW'(1);
      wr0_en_s    = 1'b0;
      wr1_en_s    = 1'b0;
      wr0_data_s  = eject_1;
      n_wr_s      = 2'd0;
      n_drop_s    = 2'd0;
      case ({v1_s, v2_s})
         2'b11: begin
            if (free_s >= TWO_C) begin
               wr0_en_s = 1'b1;
               wr1_en_s = 1'b1;
               n_wr_s   = 2'd2;
            end else if (free_s == ONE_C) begin
               wr0_en_s = 1'b1;
               n_wr_s   = 2'd1;
               n_drop_s = 2'd1;
            end else begin
               n_drop_s = 2'd2;
            end
         end
         2'b10, 2'b01: begin
            wr0_data_s = v1_s ? eject_1 : eject_2;
            if (free_s != {CW{1'b0}}) begin
               wr0_en_s = 1'b1;
               n_wr_s   = 2'd1;
            end else begin
               n_drop_s = 2'd1;
            end
         end
         default: begin
            n_wr_s = 2'd0;
         end
      endcase
      wr_ptr_d   = wr_ptr_q + AW'(n_wr_s);
      rd_ptr_d   = rd_ptr_q + AW'(pop_s);
      count_d    = count_q + CW'(n_wr_s) - CW'(pop_s);
      drop_sum_s = {1'b0, drop_cnt_q} + 9'(n_drop_s);
      drop_cnt_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
      overflow_d = overflow_q | (n_drop_s != 2'd0);
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Flit storage; contents are left as-is on reset since the pointers discard them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr0_en_s) mem_q[wr_ptr_q] <= wr0_data_s;
         if (wr1_en_s) mem_q[wr_ptr_p1_s] <= eject_2;
      end
   end

   assign out_valid   = (count_q != {CW{1'b0}});
   assign out_flit    = out_valid ? mem_q[rd_ptr_q] : {FLIT_W{1'b0}};
   assign count       = count_q;
   assign almost_full = (DEPTH_C - count_q) < TWO_C;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_minbd_eject_buffer.sv
// Directed bench for minbd_eject_buffer with a queue-based reference model checked every cycle.
module tb_minbd_eject_buffer;
   localparam int FW = 57;
   localparam int VB = 32;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] e1, e2, out_flit;
   logic          rdy, out_valid, almost_full, overflow;
   logic [3:0]    count;
   logic [7:0]    drop_cnt;

   logic [FW-1:0] nv;
   logic [FW-1:0] mq[$];
   int            m_drop, m_free, m_nd, nxt;
   bit            m_ovf, m_pop, chk_en;
   int            n_chk = 0;
   int            n_fail = 0;
   logic          r_t;

   minbd_eject_buffer #(.FLIT_W(FW), .VLD_BIT(VB), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .eject_1(e1), .eject_2(e2),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(rdy),
      .count(count), .almost_full(almost_full), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [FW-1:0] fl(input logic [31:0] d);
      return {d[23:0] ^ 24'hC3C3C3, 1'b1, d};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic r);
      e1 = a;
      e2 = b;
      rdy = r;
      @(posedge clk);
      #2;
   endtask

   // Reference model: queue of buffered flits, updated on each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_drop = 0;
         m_ovf  = 1'b0;
      end else begin
         m_pop  = (mq.size() != 0) && rdy;
         m_free = D - mq.size() + (m_pop ? 1 : 0);
         m_nd   = 0;
         if (m_pop) void'(mq.pop_front());
         if (e1[VB]) begin
            if (m_free > 0) begin mq.push_back(e1); m_free--; end
            else m_nd++;
         end
         if (e2[VB]) begin
            if (m_free > 0) begin mq.push_back(e2); m_free--; end
            else m_nd++;
         end
         if (m_nd > 0) m_ovf = 1'b1;
         m_drop = (m_drop + m_nd > 255) ? 255 : m_drop + m_nd;
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, mq.size() != 0);
         check("out_flit", out_flit, (mq.size() != 0) ? mq[0] : {FW{1'b0}});
         check("count", count, mq.size());
         check("almost_full", almost_full, (D - mq.size()) < 2);
         check("overflow", overflow, m_ovf);
         check("drop_cnt", drop_cnt, m_drop);
      end
   end

   initial begin
      nv  = {24'hFFFFFF, 1'b0, 32'hDEADBEEF};
      rst = 1'b1;
      step(nv, nv, 1'b1);
      step(nv, nv, 1'b1);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_count", count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_flit", out_flit, 0);
      check("rst_af", almost_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);

      // single eject
      step(fl(32'hA), nv, 1'b1);
      check("single_valid", out_valid, 1);
      check("single_data", out_flit[31:0], 32'hA);
      step(nv, nv, 1'b1);
      check("single_empty", out_valid, 0);
      check("single_count", count, 0);

      // dual eject
      step(fl(32'hB), fl(32'hC), 1'b1);
      check("dual_count", count, 2);
      check("dual_first", out_flit[31:0], 32'hB);
      step(nv, nv, 1'b1);
      check("dual_second", out_flit[31:0], 32'hC);
      step(nv, nv, 1'b1);
      check("dual_empty", count, 0);

      // fill and drop
      for (int k = 0; k < 5; k++) begin
         if (k == 4) check("fill_ovf_pre", overflow, 0);
         step(fl(32'h10 + 2 * k), fl(32'h11 + 2 * k), 1'b0);
         check("fill_count", count, (2 * (k + 1) > 8) ? 8 : 2 * (k + 1));
         if (k == 2) check("fill_af6", almost_full, 0);
         if (k == 3) check("fill_af8", almost_full, 1);
      end
      check("fill_ovf", overflow, 1);
      check("fill_drop", drop_cnt, 2);
      check("fill_head", out_flit[31:0], 32'h10);

      // pop on full FIFO with dual eject
      step(fl(32'h20), fl(32'h21), 1'b1);
      check("fullpop_count", count, 8);
      check("fullpop_drop", drop_cnt, 3);
      check("fullpop_head", out_flit[31:0], 32'h11);
      step(nv, nv, 1'b1);
      check("af_at7", almost_full, 1);
      step(nv, nv, 1'b1);
      check("af_at6", almost_full, 0);
      for (int i = 0; i < 12 && count != 0; i++) step(nv, nv, 1'b1);
      check("drain_count", count, 0);

      // wrap-around stream with toggling ready
      nxt = 0;
      for (int c = 0; c < 40; c++) begin
         r_t = (c % 2 == 1);
         if (out_valid && r_t) begin
            check("wrap_order", out_flit[31:0], nxt);
            nxt++;
         end
         step((c % 2 == 0) ? fl(c / 2) : nv, nv, r_t);
      end
      check("wrap_total", nxt, 20);
      check("wrap_nodrop", drop_cnt, 3);

      // mid-operation reset, including an eject_2-only cycle
      step(fl(32'h30), fl(32'h31), 1'b0);
      step(fl(32'h32), fl(32'h33), 1'b0);
      step(nv, fl(32'h34), 1'b0);
      check("pre_rst_count", count, 5);
      rst = 1'b1;
      step(fl(32'h40), fl(32'h41), 1'b1);
      rst = 1'b0;
      check("midrst_count", count, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_flit", out_flit, 0);
      check("midrst_ovf", overflow, 0);
      check("midrst_drop", drop_cnt, 0);
      step(fl(32'h77), nv, 1'b1);
      check("post_rst_data", out_flit[31:0], 32'h77);
      step(nv, nv, 1'b1);
      check("post_rst_empty", count, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/minbd_eject_buffer.md
MINBD_EJECT_BUFFER -- requirements
Module: minbd_eject_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 57, giving the width of an ejected flit (25 header bits plus 32 data bits).
REQ-002 SHALL have parameter VLD_BIT, default 32, giving the position of the flit valid bit within a flit.
REQ-003 SHALL have parameter DEPTH, default 8, giving the number of flit entries; legal values are powers of two, 4 or greater.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port eject_1, input, FLIT_W bits: first router ejection flit (router dout_l_1); valid when bit VLD_BIT = 1.
REQ-007 SHALL have port eject_2, input, FLIT_W bits: second router ejection flit (router dout_l_2); valid when bit VLD_BIT = 1.
REQ-008 SHALL have port out_flit, output, FLIT_W bits: head-of-queue flit to the local consumer.
REQ-009 SHALL have port out_valid, output, 1 bit: out_flit holds a valid flit.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_flit this cycle.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port almost_full, output, 1 bit: fewer than 2 free entries; used to throttle local injection.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when any flit is dropped.
REQ-014 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped flits.

Function
REQ-015 SHALL implement a circular FIFO with 2 write ports and 1 read port, using wr_ptr, rd_ptr and count registers; pointers wrap modulo DEPTH.
REQ-016 SHALL treat a flit as present only when its VLD_BIT is 1; all other bits of a non-valid input are ignored.
REQ-017 SHALL define pop as out_valid AND out_ready.
REQ-018 SHALL compute free space as DEPTH - count + pop, so an entry freed by a pop is reusable in the same cycle.
REQ-019 SHALL, when both inputs are valid and free space is at least 2, write eject_1 at wr_ptr and eject_2 at wr_ptr+1, then advance wr_ptr by 2.
REQ-020 SHALL, when exactly one input is valid and free space is at least 1, write that flit at wr_ptr and advance wr_ptr by 1.
REQ-021 SHALL, when both inputs are valid and free space is exactly 1, write eject_1 only and drop eject_2.
REQ-022 SHALL, when free space is 0, drop every valid input.
REQ-023 SHALL, on any drop, set overflow and add the number of dropped flits (1 or 2) to drop_cnt, saturating at 255.
REQ-024 SHALL never stall or back-pressure the ejection inputs, because the deflection router cannot hold ejected flits.
REQ-025 SHALL present the FIFO head in show-ahead form: out_flit = mem[rd_ptr], out_valid = (count != 0).
REQ-026 SHALL give a written flit a latency of 1 cycle, appearing on out_valid no earlier than the cycle after it is written; there is no combinational bypass from input to output.
REQ-027 SHALL keep out_flit stable while out_valid=1 and out_ready=0.
REQ-028 SHALL on pop advance rd_ptr by 1 and update count as count + writes - pop, all in the same edge.
REQ-029 SHALL drive out_flit to all zeros when out_valid=0.
REQ-030 SHALL assert almost_full combinationally whenever DEPTH - count < 2.
REQ-031 SHALL preserve ordering: all flits of cycle N leave before any flit of cycle N+1, and within a cycle eject_1 leaves before eject_2.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, clear wr_ptr, rd_ptr, count, overflow and drop_cnt, ignoring inputs and out_ready that cycle.
REQ-033 SHALL reset outputs to out_valid=0, out_flit=0, count=0, almost_full=0, overflow=0, drop_cnt=0.
REQ-034 SHALL, when reset is asserted mid-operation, discard all buffered flits; the memory array itself need not be cleared.

Verification
REQ-035 Bench SHALL cover single eject: eject_1 valid with data 0xA, out_ready=1 -> cycle+1 out_valid=1, out_flit data 0xA; cycle+2 out_valid=0, count=0.
REQ-036 Bench SHALL cover dual eject: eject_1 data 0xB and eject_2 data 0xC in the same cycle, out_ready=1 -> 0xB on cycle+1, 0xC on cycle+2, count peaks at 2.
REQ-037 Bench SHALL cover fill and drop: out_ready=0 with 5 cycles of dual valid ejects, DEPTH=8 -> count=8 after 4 cycles, almost_full=1 from count=7, cycle 5 drops 2, overflow=1, drop_cnt=2.
REQ-038 Bench SHALL cover a pop on a full FIFO: count=8, out_ready=1, both inputs valid -> eject_1 stored, eject_2 dropped, count stays 8, drop_cnt increments by 1.
REQ-039 Bench SHALL cover wrap-around: stream 20 single flits with data 0..19 through DEPTH=8 while out_ready toggles every cycle -> output order 0..19, no drops.
REQ-040 Bench SHALL cover mid-operation reset: count=5, pulse rst for 1 cycle -> next cycle count=0, out_valid=0, overflow=0, drop_cnt=0.
